// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch stage, the memory stage and the unified memory.
// Requesters hold *_req until their *_done pulse (fetch may also drop it via if_cancel);
// memory answers each one-cycle mem_en strobe with exactly one mem_done pulse one or
// more cycles later.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_cancel;
    logic [15:0] if_rdata;
    logic        if_done;
    logic        if_stall;
    logic        dm_req;
    logic        dm_wr;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic [15:0] dm_rdata;
    logic        dm_done;
    logic        dm_stall;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_done;
    logic        err;

    modport master (
        input  if_req, if_addr, if_cancel, dm_req, dm_wr, dm_addr, dm_wdata,
               mem_rdata, mem_done,
        output if_rdata, if_done, if_stall, dm_rdata, dm_done, dm_stall,
               mem_en, mem_wr, mem_addr, mem_wdata, err
    );

    modport slave (
        output if_req, if_addr, if_cancel, dm_req, dm_wr, dm_addr, dm_wdata,
               mem_rdata, mem_done,
        input  if_rdata, if_done, if_stall, dm_rdata, dm_done, dm_stall,
               mem_en, mem_wr, mem_addr, mem_wdata, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access, with
// fetch starvation protection, fetch cancellation and a sticky timeout flag.
module mem_port_arbiter #(
    parameter  int STARVE_MAX = 3,
    parameter  int TIMEOUT    = 15,
    localparam int SW         = $clog2(STARVE_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.master bus,
    output logic [1:0]        o_state,
    output logic [SW-1:0]     o_starve_cnt
);
    localparam int TW = 4;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DATA, S_DRAIN} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_mem_en;
    logic            r_mem_wr;
    logic [15:0]     r_mem_addr;
    logic [15:0]     r_mem_wdata;
    logic [SW-1:0]   r_starve_cnt;
    logic [TW-1:0]   r_tmo_cnt;
    logic            r_err;
    logic            w_fetch_grant;
    logic            w_data_grant;
    logic            w_if_done;
    logic            w_dm_done;
    logic            w_timeout;
    logic            w_tmo_hit;
    logic            w_starve_full;

    assign w_tmo_hit     = !bus.mem_done && (r_tmo_cnt == TW'(TIMEOUT - 1));
    assign w_starve_full = (r_starve_cnt == SW'(STARVE_MAX));

    always_comb begin
        w_state_nxt   = r_state;
        w_fetch_grant = 1'b0;
        w_data_grant  = 1'b0;
        w_if_done     = 1'b0;
        w_dm_done     = 1'b0;
        w_timeout     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_fetch_grant = bus.if_req && !bus.if_cancel && (!bus.dm_req || w_starve_full);
                w_data_grant  = !w_fetch_grant && bus.dm_req;
                if (w_fetch_grant)     w_state_nxt = S_FETCH;
                else if (w_data_grant) w_state_nxt = S_DATA;
            end
            S_FETCH: begin
                // A cancel coinciding with completion silently drops the word.
                if (bus.mem_done) begin
                    w_if_done   = !bus.if_cancel;
                    w_state_nxt = S_IDLE;
                end else if (w_tmo_hit) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (bus.if_cancel) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DATA: begin
                if (bus.mem_done) begin
                    w_dm_done   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_tmo_hit) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (bus.mem_done) begin
                    w_state_nxt = S_IDLE;
                end else if (w_tmo_hit) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_mem_en     <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_starve_cnt <= '0;
            r_tmo_cnt    <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_mem_en <= w_fetch_grant || w_data_grant;
            if (w_fetch_grant) begin
                r_mem_wr     <= 1'b0;
                r_mem_addr   <= bus.if_addr;
                r_mem_wdata  <= '0;
                r_starve_cnt <= '0;
            end else if (w_data_grant) begin
                r_mem_wr    <= bus.dm_wr;
                r_mem_addr  <= bus.dm_addr;
                r_mem_wdata <= bus.dm_wdata;
                if (bus.if_req && !w_starve_full) r_starve_cnt <= r_starve_cnt + 1'b1;
            end
            // Timer restarts on every state change, so entering DRAIN gets a fresh budget.
            if (r_state == S_IDLE || w_state_nxt != r_state) r_tmo_cnt <= '0;
            else                                              r_tmo_cnt <= r_tmo_cnt + 1'b1;
            if (w_timeout) r_err <= 1'b1;
        end
    end

    assign bus.mem_en    = r_mem_en;
    assign bus.mem_wr    = r_mem_wr;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.err       = r_err;
    assign bus.if_done   = w_if_done;
    assign bus.dm_done   = w_dm_done;
    assign bus.if_rdata  = w_if_done ? bus.mem_rdata : 16'h0000;
    assign bus.dm_rdata  = w_dm_done ? bus.mem_rdata : 16'h0000;
    assign bus.if_stall  = bus.if_req && !w_if_done;
    assign bus.dm_stall  = bus.dm_req && !w_dm_done;
    assign o_state       = r_state;
    assign o_starve_cnt  = r_starve_cnt;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change 2 time units after each rising
// edge, outputs are sampled 1 time unit later.
module tb_mem_port_arbiter;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic       clk;
    logic       rst_n;
    logic [1:0] o_state;
    logic [1:0] o_starve_cnt;
    int         checks;
    int         failures;

    mem_port_arbiter_if bus ();

    mem_port_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .o_state      (o_state),
        .o_starve_cnt (o_starve_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n         = 1'b0;
        bus.if_req    = 1'b0;
        bus.if_addr   = 16'h0000;
        bus.if_cancel = 1'b0;
        bus.dm_req    = 1'b0;
        bus.dm_wr     = 1'b0;
        bus.dm_addr   = 16'h0000;
        bus.dm_wdata  = 16'h0000;
        bus.mem_rdata = 16'h0000;
        bus.mem_done  = 1'b0;

        // reset state
        step(); step(); #1;
        chk("rst_state", 16'(o_state), 16'(ST_IDLE));
        chk("rst_mem_en", 16'(bus.mem_en), 16'h0);
        chk("rst_mem_addr", bus.mem_addr, 16'h0000);
        chk("rst_err", 16'(bus.err), 16'h0);
        chk("rst_starve", 16'(o_starve_cnt), 16'h0);
        step();
        rst_n = 1'b1;

        // lone fetch, memory latency 2
        step();
        bus.if_req = 1'b1; bus.if_addr = 16'h0040; #1;
        chk("f1_stall_req", 16'(bus.if_stall), 16'h1);
        step(); #1;
        chk("f1_mem_en", 16'(bus.mem_en), 16'h1);
        chk("f1_mem_addr", bus.mem_addr, 16'h0040);
        chk("f1_mem_wr", 16'(bus.mem_wr), 16'h0);
        chk("f1_state", 16'(o_state), 16'(ST_FETCH));
        step(); #1;
        chk("f1_en_once", 16'(bus.mem_en), 16'h0);
        chk("f1_addr_held", bus.mem_addr, 16'h0040);
        chk("f1_stall_wait", 16'(bus.if_stall), 16'h1);
        step();
        bus.mem_done = 1'b1; bus.mem_rdata = 16'hD2A4; #1;
        chk("f1_if_done", 16'(bus.if_done), 16'h1);
        chk("f1_if_rdata", bus.if_rdata, 16'hD2A4);
        chk("f1_stall_done", 16'(bus.if_stall), 16'h0);
        step();
        bus.mem_done = 1'b0; bus.mem_rdata = 16'h0000; bus.if_req = 1'b0; #1;
        chk("f1_idle", 16'(o_state), 16'(ST_IDLE));
        chk("f1_rdata_zero", bus.if_rdata, 16'h0000);

        // simultaneous fetch and store: data first
        step();
        bus.if_req = 1'b1; bus.if_addr = 16'h0010;
        bus.dm_req = 1'b1; bus.dm_wr = 1'b1; bus.dm_addr = 16'h0100; bus.dm_wdata = 16'h1234;
        step(); #1;
        chk("s_mem_en", 16'(bus.mem_en), 16'h1);
        chk("s_mem_wr", 16'(bus.mem_wr), 16'h1);
        chk("s_mem_addr", bus.mem_addr, 16'h0100);
        chk("s_mem_wdata", bus.mem_wdata, 16'h1234);
        chk("s_state", 16'(o_state), 16'(ST_DATA));
        chk("s_starve1", 16'(o_starve_cnt), 16'h1);
        step();
        bus.mem_done = 1'b1; bus.mem_rdata = 16'hBEEF; #1;
        chk("s_dm_done", 16'(bus.dm_done), 16'h1);
        chk("s_dm_rdata", bus.dm_rdata, 16'hBEEF);
        chk("s_dm_stall", 16'(bus.dm_stall), 16'h0);
        chk("s_if_stall", 16'(bus.if_stall), 16'h1);
        step();
        bus.mem_done = 1'b0; bus.mem_rdata = 16'h0000; bus.dm_req = 1'b0; bus.dm_wr = 1'b0; #1;
        chk("s_gap_idle", 16'(o_state), 16'(ST_IDLE));
        chk("s_gap_en", 16'(bus.mem_en), 16'h0);
        step(); #1;
        chk("s_f_en", 16'(bus.mem_en), 16'h1);
        chk("s_f_addr", bus.mem_addr, 16'h0010);
        chk("s_f_wr", 16'(bus.mem_wr), 16'h0);
        chk("s_f_starve0", 16'(o_starve_cnt), 16'h0);
        step();
        bus.mem_done = 1'b1; bus.mem_rdata = 16'h5555; #1;
        chk("s_f_done", 16'(bus.if_done), 16'h1);
        chk("s_f_rdata", bus.if_rdata, 16'h5555);
        step();
        bus.mem_done = 1'b0; bus.mem_rdata = 16'h0000; bus.if_req = 1'b0;

        // starvation: three back-to-back loads, then fetch wins
        step();
        bus.if_req = 1'b1; bus.if_addr = 16'h0020;
        bus.dm_req = 1'b1; bus.dm_wr = 1'b0; bus.dm_addr = 16'h0200;
        for (int i = 1; i <= 3; i++) begin
            step(); #1;
            chk("st_d_en", 16'(bus.mem_en), 16'h1);
            chk("st_d_addr", bus.mem_addr, 16'h0200);
            chk("st_d_starve", 16'(o_starve_cnt), 16'(i));
            step();
            bus.mem_done = 1'b1; bus.mem_rdata = 16'h1000 + 16'(i); #1;
            chk("st_d_done", 16'(bus.dm_done), 16'h1);
            chk("st_d_rdata", bus.dm_rdata, 16'h1000 + 16'(i));
            step();
            bus.mem_done = 1'b0; bus.mem_rdata = 16'h0000; #1;
            chk("st_idle", 16'(o_state), 16'(ST_IDLE));
        end
        step(); #1;
        chk("st_f_state", 16'(o_state), 16'(ST_FETCH));
        chk("st_f_addr", bus.mem_addr, 16'h0020);
        chk("st_f_starve0", 16'(o_starve_cnt), 16'h0);
        chk("st_dm_stall", 16'(bus.dm_stall), 16'h1);
        step();
        bus.mem_done = 1'b1; bus.mem_rdata = 16'h4321; #1;
        chk("st_f_done", 16'(bus.if_done), 16'h1);
        step();
        bus.mem_done = 1'b0; bus.mem_rdata = 16'h0000; bus.if_req = 1'b0;
        step(); #1;
        chk("st_d4_state", 16'(o_state), 16'(ST_DATA));
        chk("st_d4_starve", 16'(o_starve_cnt), 16'h0);
        step();
        bus.mem_done = 1'b1; #1;
        chk("st_d4_done", 16'(bus.dm_done), 16'h1);
        step();
        bus.mem_done = 1'b0; bus.dm_req = 1'b0;

        // cancel one cycle after mem_en, memory latency 4
        step();
        bus.if_req = 1'b1; bus.if_addr = 16'h0030;
        step(); #1;
        chk("c_en", 16'(bus.mem_en), 16'h1);
        chk("c_addr", bus.mem_addr, 16'h0030);
        step();
        bus.if_cancel = 1'b1; #1;
        chk("c_no_done", 16'(bus.if_done), 16'h0);
        step();
        bus.if_cancel = 1'b0; bus.if_addr = 16'h0002; #1;
        chk("c_drain", 16'(o_state), 16'(ST_DRAIN));
        chk("c_drain_en", 16'(bus.mem_en), 16'h0);
        step(); #1;
        chk("c_drain2", 16'(o_state), 16'(ST_DRAIN));
        step();
        bus.mem_done = 1'b1; bus.mem_rdata = 16'hFFFF; #1;
        chk("c_discard_done", 16'(bus.if_done), 16'h0);
        chk("c_discard_rdata", bus.if_rdata, 16'h0000);
        step();
        bus.mem_done = 1'b0; bus.mem_rdata = 16'h0000; #1;
        chk("c_idle", 16'(o_state), 16'(ST_IDLE));
        step(); #1;
        chk("c_refetch_en", 16'(bus.mem_en), 16'h1);
        chk("c_refetch_addr", bus.mem_addr, 16'h0002);
        step();
        bus.mem_done = 1'b1; bus.mem_rdata = 16'h0A0A; #1;
        chk("c_refetch_done", 16'(bus.if_done), 16'h1);
        chk("c_refetch_rdata", bus.if_rdata, 16'h0A0A);
        step();
        bus.mem_done = 1'b0; bus.mem_rdata = 16'h0000; bus.if_req = 1'b0;

        // timeout on a load that never completes
        step();
        bus.dm_req = 1'b1; bus.dm_wr = 1'b0; bus.dm_addr = 16'h0300;
        step(); #1;
        chk("t_en", 16'(bus.mem_en), 16'h1);
        chk("t_state", 16'(o_state), 16'(ST_DATA));
        for (int i = 2; i <= 15; i++) begin
            step(); #1;
            chk("t_wait_state", 16'(o_state), 16'(ST_DATA));
            chk("t_wait_err", 16'(bus.err), 16'h0);
        end
        step(); #1;
        chk("t_err", 16'(bus.err), 16'h1);
        chk("t_idle", 16'(o_state), 16'(ST_IDLE));
        chk("t_no_done", 16'(bus.dm_done), 16'h0);
        chk("t_stall", 16'(bus.dm_stall), 16'h1);
        step(); #1;
        chk("t_regrant_en", 16'(bus.mem_en), 16'h1);
        chk("t_regrant_addr", bus.mem_addr, 16'h0300);
        step();
        bus.mem_done = 1'b1; bus.mem_rdata = 16'h7777; #1;
        chk("t_regrant_done", 16'(bus.dm_done), 16'h1);
        chk("t_regrant_rdata", bus.dm_rdata, 16'h7777);
        step();
        bus.mem_done = 1'b0; bus.mem_rdata = 16'h0000; bus.dm_req = 1'b0; #1;
        chk("t_err_sticky", 16'(bus.err), 16'h1);

        // reset while a store waits for memory
        step();
        bus.dm_req = 1'b1; bus.dm_wr = 1'b1; bus.dm_addr = 16'h0400; bus.dm_wdata = 16'hAAAA;
        step(); #1;
        chk("r_en", 16'(bus.mem_en), 16'h1);
        chk("r_addr", bus.mem_addr, 16'h0400);
        step(); #1;
        chk("r_wait", 16'(o_state), 16'(ST_DATA));
        rst_n = 1'b0; bus.dm_req = 1'b0; #1;
        chk("r_state", 16'(o_state), 16'(ST_IDLE));
        chk("r_mem_addr", bus.mem_addr, 16'h0000);
        chk("r_mem_wdata", bus.mem_wdata, 16'h0000);
        chk("r_mem_wr", 16'(bus.mem_wr), 16'h0);
        chk("r_err", 16'(bus.err), 16'h0);
        chk("r_dm_stall", 16'(bus.dm_stall), 16'h0);
        step();
        rst_n = 1'b1;
        step();
        bus.mem_done = 1'b1; bus.mem_rdata = 16'h9999; #1;
        chk("r_late_done", 16'(bus.dm_done), 16'h0);
        chk("r_late_rdata", bus.dm_rdata, 16'h0000);
        chk("r_late_if_done", 16'(bus.if_done), 16'h0);
        step();
        bus.mem_done = 1'b0; bus.mem_rdata = 16'h0000; #1;
        chk("r_late_idle", 16'(o_state), 16'(ST_IDLE));
        chk("r_late_en", 16'(bus.mem_en), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
